// File: rtl/freq_sweep.sv
// Frequency-sweep (chirp) controller: steps the NCO control word from a start
// to a stop value with a programmable dwell, in single-shot, sawtooth or triangle mode.
module freq_sweep #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [31:0]        f_start,
   input  logic [31:0]        f_stop,
   input  logic [31:0]        f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [31:0]        ctrl,
   output logic               busy,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        ctrl_q, ctrl_d;
   logic [31:0]        beg_q, beg_d;
   logic [31:0]        end_q, end_d;
   logic [31:0]        step_q, step_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         mode_q, mode_d;
   logic               up_q, up_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // One step toward tgt, clamped at tgt; 33-bit math so a carry never wraps.
   function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] inc,
                                               input logic        up);
      logic [32:0] sum;
      logic [32:0] diff;
      sum  = {1'b0, cur} + {1'b0, inc};
      diff = {1'b0, cur} - {1'b0, tgt};
      if (up)
         return (sum > {1'b0, tgt}) ? tgt : sum[31:0];
      else
         return (diff < {1'b0, inc}) ? tgt : (cur - inc);
   endfunction

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      beg_d   = beg_q;
      end_d   = end_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      mode_d  = mode_q;
      up_d    = up_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               mode_d  = mode;
               beg_d   = f_start;
               end_d   = f_stop;
               step_d  = f_step;
               dwell_d = dwell;
               up_d    = (f_stop >= f_start);
               ctrl_d  = f_start;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != dwell_q) begin
               cnt_d = cnt_q + DWELL_W'(1);
            end else begin
               cnt_d = '0;
               if (ctrl_q == end_q) begin
                  case (mode_q)
                     2'd1: ctrl_d = beg_q;
                     // Triangle turns around without re-holding the endpoint.
                     2'd2: begin
                        beg_d  = end_q;
                        end_d  = beg_q;
                        up_d   = ~up_q;
                        ctrl_d = step_toward(ctrl_q, beg_q, step_q, ~up_q);
                     end
                     default: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  endcase
               end else begin
                  ctrl_d = step_toward(ctrl_q, end_q, step_q, up_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         beg_q   <= '0;
         end_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         mode_q  <= '0;
         up_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         beg_q   <= beg_d;
         end_q   <= end_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         mode_q  <= mode_d;
         up_q    <= up_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ctrl = ctrl_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_freq_sweep.sv
// Self-checking bench for freq_sweep: directed scenarios plus randomized sweeps
// compared cycle by cycle against a value-list reference model.
module tb_freq_sweep;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [1:0]  mode;
   logic [31:0] f_start;
   logic [31:0] f_stop;
   logic [31:0] f_step;
   logic [15:0] dwell;
   logic [31:0] ctrl;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_c[$];
   bit          exp_b[$];
   bit          exp_d[$];
   longint      tmp_l[$];
   longint      up_l[$];
   longint      dn_l[$];
   logic [31:0] last_ctrl;

   freq_sweep #(.DWELL_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .mode    (mode),
      .f_start (f_start),
      .f_stop  (f_stop),
      .f_step  (f_step),
      .dwell   (dwell),
      .ctrl    (ctrl),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] ec, input bit eb, input bit ed);
      checks++;
      assert (ctrl === ec) else begin
         errors++;
         $error("[TB] FAIL %s ctrl: observed %h expected %h", tag, ctrl, ec);
      end
      checks++;
      assert (busy === eb) else begin
         errors++;
         $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, eb);
      end
      checks++;
      assert (done === ed) else begin
         errors++;
         $error("[TB] FAIL %s done: observed %b expected %b", tag, done, ed);
      end
   endtask

   // Every value visited going from a to b, clamped at b.
   task automatic make_list(input longint a, input longint b, input longint st);
      longint v;
      tmp_l.delete();
      v = a;
      tmp_l.push_back(v);
      while (v != b && st != 0 && tmp_l.size() < 2000) begin
         if (b >= a) v = (v + st > b) ? b : v + st;
         else        v = (v - st < b) ? b : v - st;
         tmp_l.push_back(v);
      end
   endtask

   // Per-cycle expected outputs for cycles 0..n after the start edge.
   task automatic build_model(input int md, input longint a, input longint b,
                              input longint st, input int dw, input int n);
      longint seq[$];
      bit     single;
      bit     hold;
      longint last;
      exp_c.delete(); exp_b.delete(); exp_d.delete();
      make_list(a, b, st); up_l = tmp_l;
      make_list(b, a, st); dn_l = tmp_l;
      single = (md == 0 || md == 3);
      hold   = (st == 0 && a != b) || (a == b && md == 2);
      if (hold) begin
         while (seq.size() * (dw + 1) <= n + 1) seq.push_back(a);
      end else if (single) begin
         seq = up_l;
      end else if (md == 1) begin
         while (seq.size() * (dw + 1) <= n + 1)
            foreach (up_l[k]) seq.push_back(up_l[k]);
      end else begin
         seq = up_l;
         while (seq.size() * (dw + 1) <= n + 1) begin
            for (int k = 1; k < dn_l.size(); k++) seq.push_back(dn_l[k]);
            for (int k = 1; k < up_l.size(); k++) seq.push_back(up_l[k]);
         end
      end
      foreach (seq[k])
         for (int r = 0; r <= dw; r++) begin
            exp_c.push_back(32'(seq[k])); exp_b.push_back(1'b1); exp_d.push_back(1'b0);
         end
      last = seq[seq.size()-1];
      if (single && !hold) begin
         exp_c.push_back(32'(last)); exp_b.push_back(1'b0); exp_d.push_back(1'b1);
      end
      while (exp_c.size() <= n) begin
         exp_c.push_back(32'(last)); exp_b.push_back(1'b0); exp_d.push_back(1'b0);
      end
   endtask

   task automatic applyStimulus(input int md, input longint a, input longint b,
                                input longint st, input int dw);
      mode    = 2'(md);
      f_start = 32'(a);
      f_stop  = 32'(b);
      f_step  = 32'(st);
      dwell   = 16'(dw);
      start   = 1'b1;
      stop    = 1'b0;
      tick();
      start   = 1'b0;
   endtask

   // Starts a sweep and checks n cycles; leaves time in cycle n.
   task automatic run_sweep(input string tag, input int md, input longint a, input longint b,
                            input longint st, input int dw, input int n, input bit inj);
      applyStimulus(md, a, b, st, dw);
      build_model(md, a, b, st, dw, n);
      for (int i = 0; i < n; i++) begin
         checkOutput(tag, exp_c[i], exp_b[i], exp_d[i]);
         mode    = 2'($urandom_range(0, 3));
         f_start = $urandom;
         f_stop  = $urandom;
         f_step  = $urandom;
         dwell   = 16'($urandom);
         start   = inj && exp_b[i] && ($urandom_range(0, 2) == 0);
         tick();
         start   = 1'b0;
      end
   endtask

   task automatic doStop(input string tag, input int n);
      checkOutput(tag, exp_c[n], exp_b[n], exp_d[n]);
      last_ctrl = exp_c[n];
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checkOutput({tag, "_stopped"}, last_ctrl, 1'b0, 1'b0);
      tick();
      checkOutput({tag, "_idle"}, last_ctrl, 1'b0, 1'b0);
   endtask

   initial begin
      longint a, b, span, st;
      int     md, dw, n;
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      tick();
      checkOutput("reset", 32'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      checkOutput("post_reset", 32'd0, 1'b0, 1'b0);

      run_sweep("single_up", 0, 100, 130, 10, 2, 14, 1'b0);
      run_sweep("clamp_up", 0, 100, 125, 10, 0, 4, 1'b0);
      checkOutput("clamp_done", exp_c[4], exp_b[4], exp_d[4]);
      run_sweep("down", 3, 130, 100, 20, 1, 8, 1'b0);
      run_sweep("overflow", 0, 64'hFFFF_FFF0, 64'hFFFF_FFFF, 32, 0, 4, 1'b0);
      run_sweep("sawtooth", 1, 0, 30, 10, 0, 12, 1'b0);
      doStop("sawtooth", 12);
      run_sweep("triangle", 2, 0, 30, 10, 0, 16, 1'b0);
      doStop("triangle", 16);
      run_sweep("triangle_clamp", 2, 0, 25, 10, 1, 20, 1'b0);
      doStop("triangle_clamp", 20);
      run_sweep("stop_5th", 1, 0, 30, 10, 0, 4, 1'b0);
      doStop("stop_5th", 4);

      stop = 1'b1; start = 1'b1; mode = 2'd1; f_start = 32'd77; f_stop = 32'd99;
      f_step = 32'd1; dwell = 16'd0;
      tick();
      start = 1'b0; stop = 1'b0;
      checkOutput("start_stop_idle", last_ctrl, 1'b0, 1'b0);
      tick();
      checkOutput("start_stop_idle2", last_ctrl, 1'b0, 1'b0);

      run_sweep("start_in_run", 1, 1000, 1100, 30, 1, 30, 1'b1);
      doStop("start_in_run", 30);
      run_sweep("equal_single", 0, 500, 500, 7, 2, 5, 1'b0);
      run_sweep("equal_tri", 2, 500, 500, 7, 0, 8, 1'b0);
      doStop("equal_tri", 8);
      run_sweep("zero_step", 0, 10, 20, 0, 0, 10, 1'b0);
      doStop("zero_step", 10);

      run_sweep("done_restart", 0, 100, 130, 10, 2, 12, 1'b0);
      checkOutput("done_pulse", exp_c[12], exp_b[12], exp_d[12]);
      run_sweep("after_done", 0, 130, 100, 10, 0, 6, 1'b0);

      run_sweep("pre_reset", 1, 0, 30, 10, 1, 5, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset", 32'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("async_reset_hold", 32'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      run_sweep("restart", 1, 0, 30, 10, 1, 10, 1'b0);
      doStop("restart", 10);

      for (int it = 0; it < 24; it++) begin
         a    = (it % 5 == 0) ? 64'hFFFF_FF00 + $urandom_range(0, 255) : longint'($urandom);
         span = $urandom_range(0, 200);
         if ($urandom_range(0, 1) == 1) b = (a + span > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : a + span;
         else                           b = (a < span) ? 0 : a - span;
         st = $urandom_range(0, 40);
         dw = $urandom_range(0, 3);
         md = $urandom_range(0, 3);
         n  = $urandom_range(10, 60);
         run_sweep("random", md, a, b, st, dw, n, 1'b1);
         if (exp_b[n]) doStop("random", n);
         else begin
            checkOutput("random_end", exp_c[n], exp_b[n], exp_d[n]);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
